// File: rtl/maxpool_depth_scheduler.sv
// maxpool_depth_scheduler: runs one shared max-pool datapath over each depth channel in turn,
// storing each slice result and reporting done or a pool_done timeout.
module maxpool_depth_scheduler #(
  parameter int D       = 6,
  parameter int CNT_W   = 3,
  parameter int TIMEOUT = 16,
  parameter int TMR_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] depth_cfg,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic [CNT_W-1:0] slice_idx,
  output logic             pool_start,
  input  logic             pool_done,
  output logic             wr_en
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STORE, DONE} state_t;
  localparam logic [CNT_W-1:0] D_N    = CNT_W'(D);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] n_q, n_d, slice_q, slice_d;
  logic err_q, err_d;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      n_q     <= '0;
      slice_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      n_q     <= n_d;
      slice_q <= slice_d;
      err_q   <= err_d;
    end
  end
  // abort overrides every transition, so an aborted run never stores, finishes or flags an error
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    n_d     = n_q;
    slice_d = slice_q;
    err_d   = err_q;
    if (abort && state_q != IDLE) state_d = IDLE;
    else case (state_q)
      IDLE: if (start && !abort) begin
        n_d     = (depth_cfg == '0 || depth_cfg > D_N) ? D_N : depth_cfg;
        slice_d = '0;
        err_d   = 1'b0;
        state_d = ISSUE;
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: if (pool_done) state_d = STORE;
        else if (timer_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else timer_d = timer_q + 1'b1;
      STORE: if (slice_q == n_q - 1'b1) state_d = DONE;
        else begin
          slice_d = slice_q + 1'b1;
          state_d = ISSUE;
        end
      default: state_d = IDLE;
    endcase
  end
  assign busy        = state_q == ISSUE || state_q == WAIT || state_q == STORE;
  assign done        = state_q == DONE;
  assign pool_start  = state_q == ISSUE;
  assign wr_en       = state_q == STORE;
  assign err_timeout = err_q;
  assign slice_idx   = slice_q;
endmodule

// File: tb/tb_maxpool_depth_scheduler.sv
// tb_maxpool_depth_scheduler: directed runs with a responding datapath model and a wr_en slice scoreboard.
module tb_maxpool_depth_scheduler;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, pool_done = 1'b0;
  logic [2:0] depth_cfg = '0;
  logic busy, done, err_timeout, pool_start, wr_en;
  logic [2:0] slice_idx;
  int total = 0, bad = 0;
  int exp_q[$];
  int lat[6];
  int done_cyc, busy_cnt, starts, last_idx;

  maxpool_depth_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .depth_cfg(depth_cfg),
    .busy(busy), .done(done), .err_timeout(err_timeout), .slice_idx(slice_idx),
    .pool_start(pool_start), .pool_done(pool_done), .wr_en(wr_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (reset && wr_en) begin
      if (exp_q.size() == 0) chk("wr_en_unexpected", int'(slice_idx), -1);
      else chk("wr_en_slice", int'(slice_idx), exp_q.pop_front());
    end

  // miss: slice never answered; abrt: abort with pool_done on that slice; rs: reset in its WAIT
  task automatic run(input logic [2:0] cfg, input int n, input int miss, input int abrt,
                     input int rs, input int stray);
    int cnt, k, cyc, abort_cyc;
    bit fin, rpend;
    for (int s = 0; s < n; s++)
      if ((miss < 0 || s < miss) && (abrt < 0 || s < abrt) && (rs < 0 || s < rs)) exp_q.push_back(s);
    @(negedge clk);
    depth_cfg = cfg;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; cnt = -1; k = 0; fin = 0; rpend = 0; abort_cyc = -1;
    done_cyc = -1; busy_cnt = 0; starts = 0; last_idx = -1;
    while (!fin && cyc < 300) begin
      pool_done = 1'b0;
      abort = 1'b0;
      start = (cyc == stray);
      if (rpend) begin
        reset = 1'b0;
        #1;
        chk("reset_async_outputs", int'({busy, done, err_timeout, slice_idx, pool_start, wr_en}), 0);
        fin = 1;
      end else if (abort_cyc >= 0) begin
        chk("abort_idle_next", int'({busy, done, pool_start, wr_en}), 0);
        fin = 1;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          done_cyc = cyc;
          last_idx = int'(slice_idx);
          fin = 1;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            cnt = -1;
            if (k != miss) pool_done = 1'b1;
            if (k == abrt) begin
              abort = 1'b1;
              abort_cyc = cyc;
            end
            k++;
          end
        end
        if (pool_start) begin
          starts++;
          if (k == rs) rpend = 1;
          else cnt = lat[k];
        end
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    if (!fin) chk("run_cycle_budget", cyc, -1);
  endtask

  initial begin
    lat = '{1, 1, 1, 1, 1, 1};
    repeat (2) @(negedge clk);
    chk("reset_state", int'({busy, done, err_timeout, slice_idx, pool_start, wr_en}), 0);
    reset = 1'b1;

    run(3'd6, 6, -1, -1, -1, -1);
    chk("d6_done_cycle", done_cyc, 19);
    chk("d6_busy_cycles", busy_cnt, 18);
    chk("d6_pool_starts", starts, 6);
    chk("d6_err", int'(err_timeout), 0);
    chk("d6_idx_hold", last_idx, 5);
    chk("d6_queue_empty", exp_q.size(), 0);

    run(3'd0, 6, -1, -1, -1, -1);
    chk("d0_done_cycle", done_cyc, 19);
    chk("d0_pool_starts", starts, 6);
    run(3'd7, 6, -1, -1, -1, -1);
    chk("d7_done_cycle", done_cyc, 19);
    chk("d7_pool_starts", starts, 6);
    run(3'd2, 2, -1, -1, -1, -1);
    chk("d2_done_cycle", done_cyc, 7);
    chk("d2_pool_starts", starts, 2);
    chk("d2_idx_hold", last_idx, 1);
    chk("d2_queue_empty", exp_q.size(), 0);

    run(3'd6, 6, 3, -1, -1, -1);
    chk("to_done_cycle", done_cyc, 27);
    chk("to_err_set", int'(err_timeout), 1);
    chk("to_pool_starts", starts, 4);
    chk("to_queue_empty", exp_q.size(), 0);
    run(3'd2, 2, -1, -1, -1, -1);
    chk("to_err_cleared", int'(err_timeout), 0);
    chk("to_next_done", done_cyc, 7);

    run(3'd6, 6, -1, 2, -1, 3);
    chk("ab_no_done", done_cyc, -1);
    chk("ab_pool_starts", starts, 3);
    chk("ab_err", int'(err_timeout), 0);
    chk("ab_queue_empty", exp_q.size(), 0);

    lat = '{1, 5, 2, 9, 1, 3};
    run(3'd6, 6, -1, -1, -1, -1);
    chk("var_done_cycle", done_cyc, 34);
    chk("var_pool_starts", starts, 6);
    chk("var_queue_empty", exp_q.size(), 0);

    lat = '{1, 1, 1, 1, 1, 1};
    run(3'd6, 6, -1, -1, 4, -1);
    chk("rs_pool_starts", starts, 5);
    chk("rs_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("rs_held_outputs", int'({busy, done, err_timeout, slice_idx, pool_start, wr_en}), 0);
    reset = 1'b1;
    run(3'd6, 6, -1, -1, -1, -1);
    chk("rs_fresh_done", done_cyc, 19);
    chk("rs_fresh_starts", starts, 6);
    chk("rs_fresh_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
